// File: rtl/dac_pkg.sv
// Shared widths, constants and sample types for the DAC feed path.
// Also holds the round/saturate/offset-binary conversion used at the last pipeline stage.
package dac_pkg;

    localparam int SAMPLE_W = 16;
    localparam int DAC_W    = 8;
    localparam int VOL_W    = 8;
    localparam int PROD_W   = SAMPLE_W + VOL_W + 1;

    localparam logic [DAC_W-1:0] DAC_MIDSCALE = 8'h80;
    localparam logic [VOL_W-1:0] VOL_UNITY    = 8'd128;

    typedef logic signed [SAMPLE_W-1:0] sample_t;
    typedef logic signed [PROD_W-1:0]   product_t;

    // Scale by 1/128 (floor), round half up to 8 bits, clamp, then flip the sign bit.
    function automatic logic [DAC_W-1:0] to_offset_binary(input product_t p);
        product_t         y;
        product_t         z;
        logic [DAC_W-1:0] sat;
        y = p >>> 7;
        z = (y + 25'sd128) >>> 8;
        if (z > 25'sd127) begin
            sat = 8'h7F;
        end else if (z < -25'sd128) begin
            sat = 8'h80;
        end else begin
            sat = z[DAC_W-1:0];
        end
        return sat ^ DAC_MIDSCALE;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with an occupancy count; pointers wrap modulo DEPTH.
// A push while full or a pop while empty is ignored, whatever else happens that cycle.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int FW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [FW-1:0]    fill
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [FW-1:0]    fill_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (fill_r == FW'(DEPTH));
    assign empty     = (fill_r == FW'(0));
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;
    assign rdata     = mem_r[rd_ptr_r];
    assign fill      = fill_r;

    // Storage is not reset: stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            fill_r   <= FW'(0);
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   fill_r <= fill_r + FW'(1);
                2'b01:   fill_r <= fill_r - FW'(1);
                default: fill_r <= fill_r;
            endcase
        end
    end

endmodule

// File: rtl/dac_sample_feeder.sv
// Rate-paced feeder for the 8-bit delta-sigma DAC: buffers signed samples, pops one per
// sample period, applies volume, and holds the offset-binary result until the next period.
module dac_sample_feeder
    import dac_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int CLK_DIV    = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [SAMPLE_W-1:0]         s_data,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [VOL_W-1:0]            volume,
    input  logic                        underrun_clr,
    output logic [DAC_W-1:0]            dac_data,
    output logic                        sample_tick,
    output logic                        underrun,
    output logic [$clog2(FIFO_DEPTH):0] fill
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0]    div_cnt_r;
    logic             tick0_s;
    logic             accept_en_r;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic             push_s;
    logic             pop_s;
    sample_t          head_s;

    logic             s1_slot_r;
    logic             s1_bubble_r;
    sample_t          s1_data_r;
    product_t         prod_s;
    logic             s2_slot_r;
    logic             s2_bubble_r;
    product_t         s2_prod_r;
    logic [DAC_W-1:0] dac_data_r;
    logic             tick_r;
    logic             underrun_r;

    assign tick0_s     = (div_cnt_r == DIV_LAST);
    // accept_en_r keeps s_ready low until the first edge after reset release.
    assign s_ready     = accept_en_r && !fifo_full_s;
    assign push_s      = s_valid && s_ready;
    assign pop_s       = tick0_s && !fifo_empty_s;
    assign dac_data    = dac_data_r;
    assign sample_tick = tick_r;
    assign underrun    = underrun_r;

    sync_fifo #(
        .WIDTH (SAMPLE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .wdata (s_data),
        .pop   (pop_s),
        .rdata (head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .fill  (fill)
    );

    // Sample-period divider and the post-reset input enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_r   <= CW'(0);
            accept_en_r <= 1'b0;
        end else begin
            div_cnt_r   <= tick0_s ? CW'(0) : div_cnt_r + CW'(1);
            accept_en_r <= 1'b1;
        end
    end

    // Gain multiply; volume is zero-extended so it always acts as a positive factor.
    always_comb begin
        prod_s = product_t'(s1_data_r) * product_t'({1'b0, volume});
    end

    // Three-stage pop / scale / convert pipeline; a bubble keeps the last DAC value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_slot_r   <= 1'b0;
            s1_bubble_r <= 1'b1;
            s1_data_r   <= {SAMPLE_W{1'b0}};
            s2_slot_r   <= 1'b0;
            s2_bubble_r <= 1'b1;
            s2_prod_r   <= {PROD_W{1'b0}};
            dac_data_r  <= DAC_MIDSCALE;
            tick_r      <= 1'b0;
        end else begin
            s1_slot_r   <= tick0_s;
            s1_bubble_r <= fifo_empty_s;
            if (pop_s) begin
                s1_data_r <= head_s;
            end
            s2_slot_r   <= s1_slot_r;
            s2_bubble_r <= s1_bubble_r;
            s2_prod_r   <= prod_s;
            tick_r      <= s2_slot_r;
            if (s2_slot_r && !s2_bubble_r) begin
                dac_data_r <= to_offset_binary(s2_prod_r);
            end
        end
    end

    // Sticky underrun flag; a clear in the same cycle as an empty tick wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underrun_r <= 1'b0;
        end else if (underrun_clr) begin
            underrun_r <= 1'b0;
        end else if (tick0_s && fifo_empty_s) begin
            underrun_r <= 1'b1;
        end else begin
            underrun_r <= underrun_r;
        end
    end

endmodule

// File: tb/tb_dac_sample_feeder.sv
// Self-checking bench for dac_sample_feeder: directed scenarios plus random traffic,
// all checked against a queue-based reference model of the sample-period behaviour.
module tb_dac_sample_feeder;
    import dac_pkg::*;

    localparam int DEPTH = 8;
    localparam int DIV   = 16;
    localparam int FW    = $clog2(DEPTH) + 1;

    logic          clk          = 1'b0;
    logic          rst          = 1'b1;
    logic [15:0]   s_data       = 16'h0000;
    logic          s_valid      = 1'b0;
    logic          s_ready;
    logic [7:0]    volume       = VOL_UNITY;
    logic          underrun_clr = 1'b0;
    logic [7:0]    dac_data;
    logic          sample_tick;
    logic          underrun;
    logic [FW-1:0] fill;

    int n_cmp = 0;
    int n_bad = 0;

    dac_sample_feeder #(.FIFO_DEPTH(DEPTH), .CLK_DIV(DIV)) dut (
        .clk          (clk),
        .rst          (rst),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .volume       (volume),
        .underrun_clr (underrun_clr),
        .dac_data     (dac_data),
        .sample_tick  (sample_tick),
        .underrun     (underrun),
        .fill         (fill)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        int          due;
        bit          bubble;
        logic [15:0] smp;
        logic [7:0]  val;
    } ent_t;

    logic [15:0] m_q[$];
    ent_t        sched[$];
    int          m_cnt   = 0;
    int          m_edge  = 0;
    bit          m_alive = 1'b0;
    logic [7:0]  m_dac   = 8'h80;
    bit          m_tick  = 1'b0;
    bit          m_under = 1'b0;

    // round(s*vol/32768) with ties upward, clamped to a signed byte, then offset by 128
    function automatic logic [7:0] expect_dac(input logic [15:0] smp, input logic [7:0] vol);
        longint p, q, z;
        p = longint'($signed(smp)) * longint'(vol);
        q = p + 16384;
        if (q >= 0) z = q / 32768;
        else        z = -((-q + 32767) / 32768);
        if (z > 127)  z = 127;
        if (z < -128) z = -128;
        return 8'(z + 128);
    endfunction

    initial begin : ref_model
        ent_t e;
        int   pre;
        bit   tk;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_q.delete();
                sched.delete();
                m_cnt   = 0;
                m_alive = 1'b0;
                m_dac   = 8'h80;
                m_tick  = 1'b0;
                m_under = 1'b0;
            end else begin
                m_edge++;
                m_tick = 1'b0;
                if (sched.size() > 0 && sched[0].due == m_edge) begin
                    if (!sched[0].bubble) m_dac = sched[0].val;
                    m_tick = 1'b1;
                    void'(sched.pop_front());
                end
                foreach (sched[i])
                    if (sched[i].due == m_edge + 1) sched[i].val = expect_dac(sched[i].smp, volume);
                pre = m_q.size();
                tk  = (m_cnt == DIV - 1);
                if (tk) begin
                    e.due    = m_edge + 2;
                    e.bubble = (pre == 0);
                    e.smp    = 16'h0000;
                    e.val    = 8'h00;
                    if (pre != 0) e.smp = m_q.pop_front();
                    sched.push_back(e);
                end
                if (underrun_clr)        m_under = 1'b0;
                else if (tk && pre == 0) m_under = 1'b1;
                if (s_valid && m_alive && pre < DEPTH) m_q.push_back(s_data);
                m_cnt   = tk ? 0 : m_cnt + 1;
                m_alive = 1'b1;
            end
        end
    end

    // ---------------- helpers (timing only) ----------------
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_tick_cycle();
        for (int k = 0; k < 2 * DIV && m_cnt != DIV - 1; k++) cyc();
    endtask

    task automatic wait_dac_tick(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 2 * DIV + 4; k++) begin
            cyc();
            if (sample_tick === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        cyc();
        cyc();
        n_cmp++; if (dac_data !== 8'h80) begin n_bad++; $display("FAIL reset_dac: got %h want 80", dac_data); end
        n_cmp++; if (sample_tick !== 1'b0) begin n_bad++; $display("FAIL reset_tick: got %b want 0", sample_tick); end
        n_cmp++; if (underrun !== 1'b0) begin n_bad++; $display("FAIL reset_underrun: got %b want 0", underrun); end
        n_cmp++; if (fill !== FW'(0)) begin n_bad++; $display("FAIL reset_fill: got %0d want 0", fill); end
        n_cmp++; if (s_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", s_ready); end
        rst = 1'b0;
        #1;
        n_cmp++; if (s_ready !== 1'b0) begin n_bad++; $display("FAIL ready_pre_edge: got %b want 0", s_ready); end
        cyc();
        n_cmp++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL ready_post_edge: got %b want 1", s_ready); end
    endtask

    task automatic test_scaling();
        logic [15:0] smp [4];
        logic [7:0]  want [4];
        int          last_edge;
        bit          ok;
        smp  = '{16'h4000, 16'h0080, 16'h007F, 16'h8000};
        want = '{8'hC0, 8'h81, 8'h80, 8'h00};
        volume = VOL_UNITY;
        for (int i = 0; i < 4; i++) begin
            s_data = smp[i]; s_valid = 1'b1; cyc();
        end
        s_valid = 1'b0;
        last_edge = 0;
        for (int i = 0; i < 4; i++) begin
            wait_dac_tick(ok);
            n_cmp++; if (!ok) begin n_bad++; $display("FAIL scale_timeout[%0d]: got no tick want tick", i); end
            n_cmp++; if (dac_data !== want[i]) begin n_bad++; $display("FAIL scale_dac[%0d]: got %h want %h", i, dac_data, want[i]); end
            n_cmp++; if (m_cnt != 2) begin n_bad++; $display("FAIL scale_latency[%0d]: got divider phase %0d want 2", i, m_cnt); end
            if (i > 0) begin
                n_cmp++; if (m_edge - last_edge != DIV) begin n_bad++; $display("FAIL scale_period[%0d]: got %0d want %0d", i, m_edge - last_edge, DIV); end
            end
            last_edge = m_edge;
        end
    endtask

    task automatic test_saturation();
        bit ok;
        volume = 8'd255;
        s_data = 16'h7FFF; s_valid = 1'b1; cyc();
        s_data = 16'h8000; cyc();
        s_valid = 1'b0;
        wait_dac_tick(ok);
        n_cmp++; if (!ok || dac_data !== 8'hFF) begin n_bad++; $display("FAIL sat_pos: got %h want ff", dac_data); end
        wait_dac_tick(ok);
        n_cmp++; if (!ok || dac_data !== 8'h00) begin n_bad++; $display("FAIL sat_neg: got %h want 00", dac_data); end
    endtask

    task automatic test_full();
        bit ok;
        wait_tick_cycle();
        cyc();
        volume  = 8'($urandom_range(255, 1));
        s_valid = 1'b1;
        for (int i = 0; i < DEPTH + 3; i++) begin
            s_data = 16'($urandom); cyc();
        end
        n_cmp++; if (fill !== FW'(DEPTH)) begin n_bad++; $display("FAIL full_fill: got %0d want %0d", fill, DEPTH); end
        n_cmp++; if (s_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready: got %b want 0", s_ready); end
        wait_tick_cycle();
        s_data = 16'($urandom);
        cyc();
        n_cmp++; if (fill !== FW'(DEPTH - 1) || s_ready !== 1'b1) begin n_bad++; $display("FAIL full_after_pop: got fill %0d ready %b want %0d 1", fill, s_ready, DEPTH - 1); end
        s_data = 16'($urandom);
        cyc();
        s_data = 16'($urandom);
        cyc();
        cyc();
        n_cmp++; if (fill !== FW'(DEPTH) || fill !== FW'(m_q.size())) begin n_bad++; $display("FAIL full_one_more: got %0d want %0d", fill, DEPTH); end
        s_valid = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            wait_dac_tick(ok);
            n_cmp++; if (!ok || !m_tick || dac_data !== m_dac) begin n_bad++; $display("FAIL full_order[%0d]: got %h want %h", i, dac_data, m_dac); end
        end
    endtask

    task automatic test_underrun();
        logic [7:0] prev;
        for (int k = 0; k < 4 * DIV && (m_q.size() != 0 || sched.size() != 0); k++) cyc();
        underrun_clr = 1'b1; cyc(); underrun_clr = 1'b0;
        n_cmp++; if (underrun !== 1'b0) begin n_bad++; $display("FAIL urun_clear: got %b want 0", underrun); end
        wait_tick_cycle();
        cyc();
        n_cmp++; if (underrun !== 1'b1) begin n_bad++; $display("FAIL urun_set: got %b want 1", underrun); end
        prev = dac_data;
        cyc();
        cyc();
        n_cmp++; if (sample_tick !== 1'b1) begin n_bad++; $display("FAIL urun_tick: got %b want 1", sample_tick); end
        n_cmp++; if (dac_data !== prev || dac_data !== m_dac) begin n_bad++; $display("FAIL urun_hold: got %h want %h", dac_data, prev); end
        wait_tick_cycle();
        underrun_clr = 1'b1; cyc(); underrun_clr = 1'b0;
        n_cmp++; if (underrun !== 1'b0) begin n_bad++; $display("FAIL urun_clr_wins: got %b want 0", underrun); end
        cyc();
        n_cmp++; if (underrun !== 1'b0) begin n_bad++; $display("FAIL urun_stays_clear: got %b want 0", underrun); end
        wait_tick_cycle();
        cyc();
        n_cmp++; if (underrun !== 1'b1 || m_under !== 1'b1) begin n_bad++; $display("FAIL urun_reset_next: got %b want 1", underrun); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        volume = 8'($urandom_range(255, 0));
        wait_tick_cycle();
        cyc();
        s_data = 16'($urandom); s_valid = 1'b1; cyc(); s_valid = 1'b0;
        n_cmp++; if (fill !== FW'(1)) begin n_bad++; $display("FAIL b2b_pre1: got %0d want 1", fill); end
        wait_tick_cycle();
        s_data = 16'($urandom); s_valid = 1'b1; cyc(); s_valid = 1'b0;
        n_cmp++; if (fill !== FW'(1)) begin n_bad++; $display("FAIL b2b_fill1: got %0d want 1", fill); end
        for (int k = 0; k < DEPTH && m_q.size() < DEPTH - 1; k++) begin
            s_data = 16'($urandom); s_valid = 1'b1; cyc();
        end
        s_valid = 1'b0;
        n_cmp++; if (fill !== FW'(DEPTH - 1)) begin n_bad++; $display("FAIL b2b_pre7: got %0d want %0d", fill, DEPTH - 1); end
        wait_tick_cycle();
        s_data = 16'($urandom); s_valid = 1'b1; cyc(); s_valid = 1'b0;
        n_cmp++; if (fill !== FW'(DEPTH - 1)) begin n_bad++; $display("FAIL b2b_fill7: got %0d want %0d", fill, DEPTH - 1); end
        for (int i = 0; i < DEPTH + 1; i++) begin
            wait_dac_tick(ok);
            n_cmp++; if (!ok || !m_tick || dac_data !== m_dac) begin n_bad++; $display("FAIL b2b_order[%0d]: got %h want %h", i, dac_data, m_dac); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 30 * DIV; i++) begin
            s_valid      = (i < 15 * DIV) ? ($urandom_range(DIV - 1, 0) < 2) : ($urandom_range(3, 0) != 0);
            s_data       = 16'($urandom);
            underrun_clr = ($urandom_range(31, 0) == 0);
            if ($urandom_range(63, 0) == 0) volume = 8'($urandom);
            cyc();
            n_cmp++; if (dac_data !== m_dac) begin n_bad++; $display("FAIL rnd_dac@%0d: got %h want %h", i, dac_data, m_dac); end
            n_cmp++; if (sample_tick !== m_tick) begin n_bad++; $display("FAIL rnd_tick@%0d: got %b want %b", i, sample_tick, m_tick); end
            n_cmp++; if (underrun !== m_under) begin n_bad++; $display("FAIL rnd_underrun@%0d: got %b want %b", i, underrun, m_under); end
            n_cmp++; if (fill !== FW'(m_q.size())) begin n_bad++; $display("FAIL rnd_fill@%0d: got %0d want %0d", i, fill, m_q.size()); end
            n_cmp++; if (s_ready !== (m_alive && m_q.size() < DEPTH)) begin n_bad++; $display("FAIL rnd_ready@%0d: got %b", i, s_ready); end
        end
        s_valid      = 1'b0;
        underrun_clr = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit ok;
        for (int k = 0; k < (DEPTH + 2) * DIV && m_q.size() != 0; k++) cyc();
        wait_tick_cycle();
        cyc();
        for (int i = 0; i < 5; i++) begin
            s_data = 16'($urandom); s_valid = 1'b1; cyc();
        end
        s_valid = 1'b0;
        n_cmp++; if (fill !== FW'(5)) begin n_bad++; $display("FAIL mid_prefill: got %0d want 5", fill); end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if (dac_data !== 8'h80) begin n_bad++; $display("FAIL mid_dac: got %h want 80", dac_data); end
        n_cmp++; if (fill !== FW'(0)) begin n_bad++; $display("FAIL mid_fill: got %0d want 0", fill); end
        n_cmp++; if (s_ready !== 1'b0 || underrun !== 1'b0) begin n_bad++; $display("FAIL mid_flags: got ready %b underrun %b want 0 0", s_ready, underrun); end
        cyc();
        n_cmp++; if (s_ready !== 1'b0) begin n_bad++; $display("FAIL mid_ready_held: got %b want 0", s_ready); end
        rst = 1'b0;
        cyc();
        n_cmp++; if (s_ready !== 1'b1 || fill !== FW'(0)) begin n_bad++; $display("FAIL mid_release: got ready %b fill %0d want 1 0", s_ready, fill); end
        volume = VOL_UNITY;
        s_data = 16'h2000; s_valid = 1'b1; cyc(); s_valid = 1'b0;
        wait_dac_tick(ok);
        n_cmp++; if (!ok || dac_data !== 8'hA0) begin n_bad++; $display("FAIL mid_fresh: got %h want a0", dac_data); end
    endtask

    initial begin
        test_reset();
        test_scaling();
        test_saturation();
        test_full();
        test_underrun();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
